// File: rtl/eq_fir_sequencer_pkg.sv
// ============================================================================
// Module   : eq_pkg
// Purpose  : Shared sizes, types and helpers for the eq_fir_sequencer slice.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package eq_pkg;

  localparam int FILTER_SIZE = 100;
  localparam int NUM_BANDS   = 3;
  localparam int AUDIO_DEPTH = 16;
  localparam int GAIN_W      = 8;
  localparam int COEFF_SHIFT = 9;
  localparam int ACC_W       = 40;

  localparam int NUM_TAPS = FILTER_SIZE + 1;
  localparam int PTR_W    = $clog2(NUM_TAPS);
  localparam int BAND_W   = $clog2(NUM_BANDS);
  localparam int MIX_W    = ACC_W + GAIN_W + 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MAC     = 2'd1,
    COMBINE = 2'd2,
    OUT     = 2'd3
  } eq_state_t;

  typedef logic signed [AUDIO_DEPTH-1:0]   sample_t;
  typedef logic signed [AUDIO_DEPTH-1:0]   coeff_t;
  typedef logic signed [ACC_W-1:0]         acc_t;
  typedef logic signed [2*AUDIO_DEPTH-1:0] prod_t;
  typedef logic signed [MIX_W-1:0]         mix_t;
  typedef logic        [GAIN_W-1:0]        gain_t;
  typedef logic        [PTR_W-1:0]         ptr_t;
  typedef logic        [BAND_W-1:0]        band_t;

  localparam mix_t SAT_MAX = mix_t'((2 ** (AUDIO_DEPTH - 1)) - 1);
  localparam mix_t SAT_MIN = mix_t'(-(2 ** (AUDIO_DEPTH - 1)));

  // (a - b) mod NUM_TAPS for a, b < NUM_TAPS; the +NUM_TAPS branch
  // relies on modular PTR_W arithmetic since the true result fits.
  function automatic ptr_t ptr_sub(input ptr_t a, input ptr_t b);
    if (a >= b) return a - b;
    return a - b + ptr_t'(NUM_TAPS);
  endfunction

endpackage

`default_nettype wire

// File: rtl/eq_fir_sequencer_if.sv
// ============================================================================
// Module   : eq_fir_sequencer_if
// Purpose  : Sample-in / sample-out valid-ready bundle of the FIR sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface eq_fir_sequencer_if
  import eq_pkg::*;
();

  sample_t in_data;
  logic    in_valid;
  logic    in_ready;
  sample_t out_data;
  logic    out_valid;
  logic    out_ready;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid
  );

endinterface

`default_nettype wire

// File: rtl/eq_fir_sequencer_delay_line.sv
// ============================================================================
// Module   : eq_delay_line
// Purpose  : Circular sample buffer; write at wr_ptr, read at (base - tap).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module eq_delay_line
  import eq_pkg::*;
(
  input  logic    clk,
  input  logic    rst,
  input  logic    i_wr_en,
  input  sample_t i_wr_data,
  input  ptr_t    i_base,
  input  ptr_t    i_tap,
  output ptr_t    o_wr_ptr,
  output sample_t o_rd_data
);

  localparam ptr_t LAST_IDX = ptr_t'(FILTER_SIZE);

  sample_t r_mem [NUM_TAPS];
  ptr_t    r_wr_ptr;
  ptr_t    w_rd_idx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      for (int i = 0; i < NUM_TAPS; i++) r_mem[i] <= '0;
    end else if (i_wr_en) begin
      r_mem[r_wr_ptr] <= i_wr_data;
      r_wr_ptr        <= (r_wr_ptr == LAST_IDX) ? '0 : r_wr_ptr + ptr_t'(1);
    end
  end

  assign w_rd_idx  = ptr_sub(i_base, i_tap);
  assign o_rd_data = r_mem[w_rd_idx];
  assign o_wr_ptr  = r_wr_ptr;

endmodule

`default_nettype wire

// File: rtl/eq_fir_sequencer.sv
// ============================================================================
// Module   : eq_fir_sequencer
// Purpose  : Time-multiplexed 3-band FIR equalizer, one MAC step per cycle.
//            EQ_SAT_COUNT_EN adds the sat_count clamp counter output.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module eq_fir_sequencer
  import eq_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  coeff_t coeff     [NUM_BANDS][NUM_TAPS],
  input  gain_t  band_gain [NUM_BANDS],
`ifdef EQ_SAT_COUNT_EN
  output logic [15:0] sat_count,
`endif
  eq_fir_sequencer_if.slave bus
);

  localparam ptr_t  LAST_TAP  = ptr_t'(FILTER_SIZE);
  localparam band_t LAST_BAND = band_t'(NUM_BANDS - 1);

  eq_state_t r_state, w_next_state;
  ptr_t      r_base, r_tap, w_wr_ptr;
  band_t     r_band;
  acc_t      r_acc, w_prod_ext;
  acc_t      r_band_acc [NUM_BANDS];
  sample_t   r_out_data, w_rd_data, w_sat_data;
  logic      r_out_valid, w_accept, w_last_tap, w_sat_hi, w_sat_lo;
  prod_t     w_prod;
  mix_t      w_mix, w_shift;

  eq_delay_line u_dline (
    .clk       (clk),
    .rst       (rst),
    .i_wr_en   (w_accept),
    .i_wr_data (bus.in_data),
    .i_base    (r_base),
    .i_tap     (r_tap),
    .o_wr_ptr  (w_wr_ptr),
    .o_rd_data (w_rd_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_next_state = MAC;
      MAC:     if (w_last_tap && (r_band == LAST_BAND)) w_next_state = COMBINE;
      COMBINE: w_next_state = OUT;
      OUT:     if (bus.out_ready) w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready  = (r_state == IDLE);
    bus.out_data  = r_out_data;
    bus.out_valid = r_out_valid;
    w_accept      = bus.in_valid && (r_state == IDLE);
    w_last_tap    = (r_tap == LAST_TAP);
  end

  assign w_prod     = prod_t'(coeff[r_band][r_tap]) * prod_t'(w_rd_data);
  assign w_prod_ext = acc_t'(w_prod);

  // Gain is zero-extended so 255 stays positive in the signed product.
  always_comb begin
    w_mix = '0;
    for (int b = 0; b < NUM_BANDS; b++)
      w_mix = w_mix + mix_t'(r_band_acc[b]) * mix_t'($signed({1'b0, band_gain[b]}));
  end

  always_comb begin
    w_shift    = w_mix >>> (COEFF_SHIFT + 7);
    w_sat_hi   = (w_shift > SAT_MAX);
    w_sat_lo   = (w_shift < SAT_MIN);
    w_sat_data = sample_t'(w_shift);
    if (w_sat_hi) w_sat_data = sample_t'(SAT_MAX);
    if (w_sat_lo) w_sat_data = sample_t'(SAT_MIN);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_base      <= '0;
      r_tap       <= '0;
      r_band      <= '0;
      r_acc       <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      for (int b = 0; b < NUM_BANDS; b++) r_band_acc[b] <= '0;
    end else begin
      case (r_state)
        IDLE: if (w_accept) begin
          r_base <= w_wr_ptr;
          r_tap  <= '0;
          r_band <= '0;
          r_acc  <= '0;
        end
        MAC: if (w_last_tap) begin
          r_band_acc[r_band] <= r_acc + w_prod_ext;
          r_acc              <= '0;
          r_tap              <= '0;
          if (r_band != LAST_BAND) r_band <= r_band + band_t'(1);
        end else begin
          r_acc <= r_acc + w_prod_ext;
          r_tap <= r_tap + ptr_t'(1);
        end
        COMBINE: begin
          r_out_data  <= w_sat_data;
          r_out_valid <= 1'b1;
        end
        OUT: if (bus.out_ready) r_out_valid <= 1'b0;
        default: ;
      endcase
    end
  end

`ifdef EQ_SAT_COUNT_EN
  logic [15:0] r_sat_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_sat_count <= '0;
    else if ((r_state == COMBINE) && (w_sat_hi || w_sat_lo) && (r_sat_count != 16'hFFFF))
      r_sat_count <= r_sat_count + 16'd1;
  end

  assign sat_count = r_sat_count;
`endif

endmodule

`default_nettype wire
